// File: rtl/prv664_sm_pkg.sv
// ----------------------------------------------------------------------------
// prv664_sm_pkg
//   Shared types for the store-manage responder: FSM state encoding, the
//   latched request descriptor and the priority skip function that picks the
//   next requested sub-operation.
// ----------------------------------------------------------------------------
package prv664_sm_pkg;

    localparam int unsigned SM_ITAG_W = 8;

    // Encoding order is the execution order; next_state() relies on it.
    typedef enum logic [2:0] {
        IDLE,
        COMMIT,
        DRAIN,
        DCWB,
        ICINV,
        TLBF,
        DONE
    } sm_state_e;

    typedef struct packed {
        logic                 fence;
        logic                 fencevma;
        logic                 fencei;
        logic                 commit;
        logic [SM_ITAG_W-1:0] itag;
    } sm_op_t;

    // First requested state strictly after cur; DONE when nothing is left.
    // Later assignments win, so the earliest requested state is returned.
    function automatic sm_state_e next_state(sm_state_e cur, sm_op_t op);
        sm_state_e ns;
        ns = DONE;
        if (cur < TLBF  && op.fencevma)                          ns = TLBF;
        if (cur < ICINV && op.fencei)                            ns = ICINV;
        if (cur < DCWB  && (op.fence || op.fencei))              ns = DCWB;
        if (cur < DRAIN && (op.fence || op.fencevma || op.fencei)) ns = DRAIN;
        if (cur < COMMIT && op.commit)                           ns = COMMIT;
        return ns;
    endfunction

endpackage

// File: rtl/sm_drain_timer.sv
// ----------------------------------------------------------------------------
// sm_drain_timer
//   Wait counter for the store-buffer drain. Counts while enabled, returns to
//   zero on clear, and saturates at TMO-1 where expire_o is raised.
// Ports
//   clk_i     in  clock
//   srst_i    in  synchronous active-high reset
//   clr_i     in  force count back to zero
//   en_i      in  count this cycle
//   expire_o  out count has reached TMO-1 while enabled
// ----------------------------------------------------------------------------
module sm_drain_timer #(
    parameter int unsigned TMO = 1024
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    // At least 10 bits so the default timeout fits without a parameter change.
    localparam int unsigned CNT_W = (TMO > 1024) ? $clog2(TMO) : 10;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign expire_o  = en_i && w_at_last;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (srst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/store_manage_responder.sv
// ----------------------------------------------------------------------------
// store_manage_responder
//   Slave end of the store-manage channel. An accepted request is expanded
//   into the ordered sub-operations COMMIT, DRAIN, DCWB, ICINV, TLBF; skipped
//   ones are not visited. sm_ready_o pulses once when all are complete.
// Ports
//   clk_i, srst_i                     clock, synchronous active-high reset
//   sm_valid_i / sm_ready_o           request handshake (ready is a 1-cycle pulse)
//   sm_fence_i, sm_fencevma_i,
//   sm_fencei_i, sm_commit_i,
//   sm_itag_i                         request fields, latched on accept
//   sb_cmt_valid_o/itag_o/ready_i     store-buffer commit handshake
//   sb_empty_i                        store buffer drained
//   dc_wb_req_o / dc_wb_ack_i         D-cache write-back (level req, pulse ack)
//   ic_inv_req_o / ic_inv_ack_i       I-cache invalidate
//   tlb_flush_req_o / tlb_flush_ack_i TLB flush
//   busy_o                            FSM not in IDLE
//   drain_tmo_o                       sticky drain-timeout flag
// ----------------------------------------------------------------------------
module store_manage_responder
    import prv664_sm_pkg::*;
#(
    parameter int unsigned ITAG_W    = SM_ITAG_W,
    parameter int unsigned DRAIN_TMO = 1024
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              sm_valid_i,
    output logic              sm_ready_o,
    input  logic              sm_fence_i,
    input  logic              sm_fencevma_i,
    input  logic              sm_fencei_i,
    input  logic              sm_commit_i,
    input  logic [ITAG_W-1:0] sm_itag_i,
    output logic              sb_cmt_valid_o,
    output logic [ITAG_W-1:0] sb_cmt_itag_o,
    input  logic              sb_cmt_ready_i,
    input  logic              sb_empty_i,
    output logic              dc_wb_req_o,
    input  logic              dc_wb_ack_i,
    output logic              ic_inv_req_o,
    input  logic              ic_inv_ack_i,
    output logic              tlb_flush_req_o,
    input  logic              tlb_flush_ack_i,
    output logic              busy_o,
    output logic              drain_tmo_o
);

    sm_state_e r_state;
    sm_state_e w_next;
    sm_op_t    r_op;
    sm_op_t    w_op_in;
    logic      r_drain_tmo;
    logic      w_in_drain;
    logic      w_expire;

    assign w_op_in.fence    = sm_fence_i;
    assign w_op_in.fencevma = sm_fencevma_i;
    assign w_op_in.fencei   = sm_fencei_i;
    assign w_op_in.commit   = sm_commit_i;
    assign w_op_in.itag     = SM_ITAG_W'(sm_itag_i);

    assign w_in_drain  = (r_state == DRAIN);
    assign drain_tmo_o = r_drain_tmo;

    sm_drain_timer #(
        .TMO      (DRAIN_TMO)
    ) u_drain_timer (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .clr_i    (!w_in_drain),
        .en_i     (w_in_drain),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_drain_tmo <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && sm_valid_i) begin
                r_op <= w_op_in;
            end
            if (w_expire) begin
                r_drain_tmo <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next          = r_state;
        sm_ready_o      = 1'b0;
        sb_cmt_valid_o  = 1'b0;
        sb_cmt_itag_o   = '0;
        dc_wb_req_o     = 1'b0;
        ic_inv_req_o    = 1'b0;
        tlb_flush_req_o = 1'b0;
        busy_o          = (r_state != IDLE);

        unique case (r_state)
            IDLE: begin
                // Always enter COMMIT: it is the first cycle in which r_op is
                // valid, so it doubles as the decode cycle for the skip logic.
                if (sm_valid_i) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                sb_cmt_valid_o = r_op.commit;
                if (r_op.commit) begin
                    sb_cmt_itag_o = ITAG_W'(r_op.itag);
                end
                if (!r_op.commit || sb_cmt_ready_i) begin
                    w_next = next_state(COMMIT, r_op);
                end
            end
            DRAIN: begin
                // A timeout only raises the flag; the wait continues.
                if (sb_empty_i) begin
                    w_next = next_state(DRAIN, r_op);
                end
            end
            DCWB: begin
                dc_wb_req_o = 1'b1;
                if (dc_wb_ack_i) begin
                    w_next = next_state(DCWB, r_op);
                end
            end
            ICINV: begin
                ic_inv_req_o = 1'b1;
                if (ic_inv_ack_i) begin
                    w_next = next_state(ICINV, r_op);
                end
            end
            TLBF: begin
                tlb_flush_req_o = 1'b1;
                if (tlb_flush_ack_i) begin
                    w_next = next_state(TLBF, r_op);
                end
            end
            DONE: begin
                sm_ready_o = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
